// File: rtl/serializador_palavra_pkg.sv
// Shared types and helpers for the word serializer: FSM states, default width, counter sizing.
package serializador_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    DESLOCA,
    PARIDADE,
    INTERVALO
  } estado_t;

  localparam int LARGURA_PADRAO = 4;

  // Never narrower than one bit, so a count of 1 still gets a real register.
  function automatic int larguraContador(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializador_palavra_contador_bits.sv
// Loadable down-counter with a terminal flag decoded from the registered count.
module contador_bits
  import serializador_pkg::*;
#(
  parameter int W = larguraContador(LARGURA_PADRAO)
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         carregar,
  input  logic         decrementar,
  input  logic [W-1:0] valorCarga,
  output logic         terminal
);

  logic [W-1:0] r_contagem;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_contagem <= '0;
    end else if (carregar) begin
      r_contagem <= valorCarga;
    end else if (decrementar) begin
      r_contagem <= r_contagem - W'(1);
    end
  end

  assign terminal = (r_contagem == '0);

endmodule

// File: rtl/serializador_palavra.sv
// Parallel-to-serial word source, MSB first, with valid/ready intake and optional idle gap.
// Define SERIALIZADOR_PARIDADE_EN to append one even-parity bit after every word.
module serializador_palavra
  import serializador_pkg::*;
#(
  parameter int LARGURA   = LARGURA_PADRAO,
  parameter int INTERVALO = 0
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic [LARGURA-1:0] palavra,
  input  logic               palavraValida,
  output logic               pronto,
  output logic               novoBit,
  output logic               bitValido,
  output logic               ehParidade,
  output logic               ocupado
);

  localparam int W_BITS = larguraContador(LARGURA);
  localparam int W_INT  = larguraContador((INTERVALO < 2) ? 2 : INTERVALO);
  localparam logic [W_BITS-1:0] CARGA_BITS = W_BITS'(LARGURA - 1);
  localparam logic [W_INT-1:0]  CARGA_INT  = W_INT'((INTERVALO > 0) ? INTERVALO - 1 : 0);
  localparam estado_t POS_PALAVRA = (INTERVALO > 0) ? serializador_pkg::INTERVALO : OCIOSO;

  estado_t            r_estado;
  logic [LARGURA-1:0] r_desloca;
  logic               r_ativo;
`ifdef SERIALIZADOR_PARIDADE_EN
  logic               r_paridade;
`endif

  logic w_aceita;
  logic w_fimPalavra;
  logic w_bitsFim;
  logic w_intFim;
  logic w_decBits;
  logic w_carregaInt;
  logic w_decInt;

  // r_ativo holds pronto low on the first cycle after reset releases.
  assign w_aceita = (r_estado == OCIOSO) && r_ativo && palavraValida;
`ifdef SERIALIZADOR_PARIDADE_EN
  assign w_fimPalavra = (r_estado == PARIDADE);
`else
  assign w_fimPalavra = (r_estado == DESLOCA) && w_bitsFim;
`endif
  assign w_decBits    = (r_estado == DESLOCA) && !w_bitsFim;
  assign w_carregaInt = w_fimPalavra && (INTERVALO > 0);
  assign w_decInt     = (r_estado == serializador_pkg::INTERVALO) && !w_intFim;

  contador_bits #(.W(W_BITS)) u_contaBits (
    .clock       (clock),
    .resetN      (resetN),
    .carregar    (w_aceita),
    .decrementar (w_decBits),
    .valorCarga  (CARGA_BITS),
    .terminal    (w_bitsFim)
  );

  contador_bits #(.W(W_INT)) u_contaIntervalo (
    .clock       (clock),
    .resetN      (resetN),
    .carregar    (w_carregaInt),
    .decrementar (w_decInt),
    .valorCarga  (CARGA_INT),
    .terminal    (w_intFim)
  );

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_estado   <= OCIOSO;
      r_desloca  <= '0;
      r_ativo    <= 1'b0;
`ifdef SERIALIZADOR_PARIDADE_EN
      r_paridade <= 1'b0;
`endif
    end else begin
      r_ativo <= 1'b1;
      case (r_estado)
        OCIOSO: begin
          if (w_aceita) begin
            r_desloca  <= palavra;
`ifdef SERIALIZADOR_PARIDADE_EN
            r_paridade <= ^palavra;
`endif
            r_estado   <= DESLOCA;
          end
        end
        DESLOCA: begin
          r_desloca <= {r_desloca[LARGURA-2:0], 1'b0};
          if (w_bitsFim) begin
`ifdef SERIALIZADOR_PARIDADE_EN
            r_estado <= PARIDADE;
`else
            r_estado <= POS_PALAVRA;
`endif
          end
        end
`ifdef SERIALIZADOR_PARIDADE_EN
        PARIDADE: r_estado <= POS_PALAVRA;
`endif
        serializador_pkg::INTERVALO: begin
          if (w_intFim) r_estado <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign pronto  = (r_estado == OCIOSO) && r_ativo;
  assign ocupado = (r_estado != OCIOSO);
`ifdef SERIALIZADOR_PARIDADE_EN
  assign bitValido  = (r_estado == DESLOCA) || (r_estado == PARIDADE);
  assign ehParidade = (r_estado == PARIDADE);
  assign novoBit    = ((r_estado == DESLOCA) && r_desloca[LARGURA-1])
                    || ((r_estado == PARIDADE) && r_paridade);
`else
  assign bitValido  = (r_estado == DESLOCA);
  assign ehParidade = 1'b0;
  assign novoBit    = (r_estado == DESLOCA) && r_desloca[LARGURA-1];
`endif

endmodule

// File: tb/tb_serializador_palavra.sv
// Directed self-checking bench for serializador_palavra; two instances cover INTERVALO=0 and 3.
// Parity expectations follow SERIALIZADOR_PARIDADE_EN.
module tb_serializador_palavra;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       palavraValida = 1'b0;
  logic [3:0] palavra = 4'h0;

  logic pronto, novoBit, bitValido, ehParidade, ocupado;
  logic prontoI, novoBitI, bitValidoI, ehParidadeI, ocupadoI;
  logic [3:0] rioAbaixo = 4'h0;

  int nChecks = 0;
  int nPass = 0;
  int nFail = 0;

  always #5 clock = ~clock;

  serializador_palavra #(.LARGURA(4), .INTERVALO(0)) dut (
    .clock         (clock),
    .resetN        (resetN),
    .palavra       (palavra),
    .palavraValida (palavraValida),
    .pronto        (pronto),
    .novoBit       (novoBit),
    .bitValido     (bitValido),
    .ehParidade    (ehParidade),
    .ocupado       (ocupado)
  );

  serializador_palavra #(.LARGURA(4), .INTERVALO(3)) dutInt (
    .clock         (clock),
    .resetN        (resetN),
    .palavra       (palavra),
    .palavraValida (palavraValida),
    .pronto        (prontoI),
    .novoBit       (novoBitI),
    .bitValido     (bitValidoI),
    .ehParidade    (ehParidadeI),
    .ocupado       (ocupadoI)
  );

  // Downstream 4-stage serial-in register: bit 3 is the last stage.
  always @(posedge clock) rioAbaixo <= {rioAbaixo[2:0], novoBit};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] w, input logic valido);
    palavra = w;
    palavraValida = valido;
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    palavraValida = 1'b0;
    tick();
    tick();
    checkOutput("rst_pronto", pronto, 4'h0);
    checkOutput("rst_ocupado", ocupado, 4'h0);
    checkOutput("rst_valido", bitValido, 4'h0);
    checkOutput("rst_bit", novoBit, 4'h0);
    checkOutput("rst_paridade", ehParidade, 4'h0);
    checkOutput("rst_prontoInt", prontoI, 4'h0);
    resetN = 1'b1;
    tick();
    checkOutput("rst_prontoApos", pronto, 4'h1);
    checkOutput("rst_prontoAposInt", prontoI, 4'h1);
  endtask

  // Called just after the accepting edge; returns just after the last bit's cycle ends.
  task automatic checkBits(input string tag, input bit useInt,
                           input logic [3:0] w, input logic [3:0] proxima);
    palavra = proxima;
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_valido"}, useInt ? bitValidoI : bitValido, 4'h1);
      checkOutput({tag, "_bit"}, useInt ? novoBitI : novoBit, {3'b000, w[3-i]});
      checkOutput({tag, "_pronto"}, useInt ? prontoI : pronto, 4'h0);
      checkOutput({tag, "_ocupado"}, useInt ? ocupadoI : ocupado, 4'h1);
      checkOutput({tag, "_ehParidade"}, useInt ? ehParidadeI : ehParidade, 4'h0);
      tick();
    end
    if (!useInt) checkOutput({tag, "_rioAbaixo"}, rioAbaixo, w);
`ifdef SERIALIZADOR_PARIDADE_EN
    checkOutput({tag, "_parValido"}, useInt ? bitValidoI : bitValido, 4'h1);
    checkOutput({tag, "_parFlag"}, useInt ? ehParidadeI : ehParidade, 4'h1);
    checkOutput({tag, "_parBit"}, useInt ? novoBitI : novoBit, {3'b000, ^w});
    tick();
`endif
  endtask

  task automatic checkGap(input string tag);
    checkOutput({tag, "_gapPronto"}, pronto, 4'h1);
    checkOutput({tag, "_gapValido"}, bitValido, 4'h0);
    checkOutput({tag, "_gapBit"}, novoBit, 4'h0);
    checkOutput({tag, "_gapOcupado"}, ocupado, 4'h0);
  endtask

  initial begin
    // Basic word 1011
    applyReset();
    applyStimulus(4'b1011, 1'b1);
    tick();
    palavraValida = 1'b0;
    checkBits("basico", 1'b0, 4'b1011, 4'b1011);
    checkGap("basico");

    // Parity-zero case 1001
    applyStimulus(4'b1001, 1'b1);
    tick();
    palavraValida = 1'b0;
    checkBits("par1001", 1'b0, 4'b1001, 4'b1001);
    checkGap("par1001");

    // Back-to-back A then 5 with valid held high
    applyStimulus(4'hA, 1'b1);
    tick();
    checkBits("seqA", 1'b0, 4'hA, 4'h5);
    checkGap("seqA");
    tick();
    palavraValida = 1'b0;
    checkBits("seq5", 1'b0, 4'h5, 4'h5);
    checkGap("seq5");

    // Word held during busy, palavra changed to F mid-word
    applyStimulus(4'h6, 1'b1);
    tick();
    checkBits("ocup6", 1'b0, 4'h6, 4'hF);
    checkGap("ocup6");
    tick();
    palavraValida = 1'b0;
    checkBits("ocupF", 1'b0, 4'hF, 4'hF);
    checkGap("ocupF");

    // Reset mid-word on 4'hC at edge 2
    applyStimulus(4'hC, 1'b1);
    tick();
    palavraValida = 1'b0;
    checkOutput("rstMeio_bit0", novoBit, 4'h1);
    tick();
    checkOutput("rstMeio_bit1", novoBit, 4'h1);
    resetN = 1'b0;
    tick();
    checkOutput("rstMeio_valido", bitValido, 4'h0);
    checkOutput("rstMeio_bit", novoBit, 4'h0);
    checkOutput("rstMeio_ocupado", ocupado, 4'h0);
    checkOutput("rstMeio_pronto", pronto, 4'h0);
    resetN = 1'b1;
    tick();
    checkOutput("rstMeio_prontoApos", pronto, 4'h1);
    checkOutput("rstMeio_validoApos", bitValido, 4'h0);
    tick();
    checkOutput("rstMeio_semBits", bitValido, 4'h0);
    checkOutput("rstMeio_semBitsLinha", novoBit, 4'h0);

    // Idle interval of 3 cycles on the second instance
    applyReset();
    applyStimulus(4'h9, 1'b1);
    tick();
    checkBits("intervalo9", 1'b1, 4'h9, 4'h3);
    for (int k = 0; k < 3; k++) begin
      checkOutput("intervalo_pronto", prontoI, 4'h0);
      checkOutput("intervalo_valido", bitValidoI, 4'h0);
      checkOutput("intervalo_bit", novoBitI, 4'h0);
      checkOutput("intervalo_ocupado", ocupadoI, 4'h1);
      tick();
    end
    checkOutput("intervalo_prontoFim", prontoI, 4'h1);
    checkOutput("intervalo_validoFim", bitValidoI, 4'h0);
    tick();
    palavraValida = 1'b0;
    checkBits("intervalo3", 1'b1, 4'h3, 4'h3);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
